// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring round-robin arbiter: FSM states and parameter defaults.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

endpackage : ring_arb_pkg

// File: rtl/token_ring.sv
// One-hot priority token register with synchronous load and rotate-up-by-one.
module token_ring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         rotate,
    output logic [N-1:0] token
);

    // Load wins over rotate; the MSB wraps back to the LSB on rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            token <= N'(1);
        end else if (load) begin
            token <= load_val;
        end else if (rotate) begin
            token <= {token[N-2:0], token[N-1]};
        end
    end

endmodule : token_ring

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the token position,
// holds the grant until done or a forced release after MAX_HOLD cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] grant,
    output logic [N-1:0] token,
    output logic         busy,
    output logic         timeout,
    output logic         load_err
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N-1:0] masked_req;
    logic [N-1:0] pick_src;
    logic [N-1:0] pick;
    logic [N-1:0] rot_grant;
    logic [N-1:0] tok_val;
    logic         load_ok;
    logic         hold_last;
    logic         release_now;
    logic         tok_load;
    logic         tok_rot;

    // Requests at or above the token are preferred; if none, the lowest request
    // overall is the wrapped-around winner. x & -x isolates the lowest set bit.
    always_comb begin
        masked_req  = req & ~(token - N'(1));
        pick_src    = (masked_req != '0) ? masked_req : req;
        pick        = pick_src & (~pick_src + N'(1));
        load_ok     = (load_val != '0) && ((load_val & (load_val - N'(1))) == '0);
        hold_last   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        release_now = (state == GRANT) && (done || hold_last);
        rot_grant   = {grant[N-2:0], grant[N-1]};

        tok_load = 1'b0;
        tok_rot  = 1'b0;
        tok_val  = load_val;
        if ((state == IDLE) && load && load_ok) begin
            tok_load = 1'b1;
        end else if (release_now) begin
            // A rotate suffices when the token still points at the holder.
            if (grant == token) begin
                tok_rot = 1'b1;
            end else begin
                tok_load = 1'b1;
                tok_val  = rot_grant;
            end
        end
    end

    token_ring #(
        .N(N)
    ) u_token_ring (
        .clk      (clk),
        .rst      (rst),
        .load     (tok_load),
        .load_val (tok_val),
        .rotate   (tok_rot),
        .token    (token)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            load_err <= 1'b0;
            hold_cnt <= '0;
        end else begin
            timeout  <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (!load_ok) begin
                            load_err <= 1'b1;
                        end
                    end else if (req != '0) begin
                        state    <= GRANT;
                        grant    <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (load) begin
                        load_err <= 1'b1;
                    end
                    if (release_now) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        timeout  <= !done;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule : ring_rr_arbiter
